// File: rtl/dcache_write_buffer.sv
// Line-granular write-back buffer between the dcache eviction port and the AXI cached-write port.
// Buffers dirty lines in FIFO order, coalesces rewrites of queued lines, and serves miss-path snoops.
//
// state  | meaning
// IDLE   | head not issued; start a write when any entry is valid
// REQ    | wr_req asserted with the head line, waiting for wr_rdy
// WAIT_B | head line issued, waiting for wr_bvalid to retire it
module dcache_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 128
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_req,
  input  logic [31:0]              in_addr,
  input  logic [LINE_W-1:0]        in_data,
  output logic                     in_rdy,
  output logic                     wr_req,
  output logic [31:0]              wr_addr,
  output logic [LINE_W-1:0]        wr_data,
  input  logic                     wr_rdy,
  input  logic                     wr_bvalid,
  input  logic [31:0]              snoop_addr,
  output logic                     snoop_hit,
  output logic [LINE_W-1:0]        snoop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_B} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [27:0]       tag_q   [DEPTH];
  logic [27:0]       tag_d   [DEPTH];
  logic [LINE_W-1:0] data_q  [DEPTH];
  logic [LINE_W-1:0] data_d  [DEPTH];

  logic              coal_hit;
  logic [PW-1:0]     coal_idx;
  logic              not_full, push, pop;
  logic [PW-1:0]     snp_idx;
  logic              unused_lo;

  assign unused_lo = ^{in_addr[3:0], snoop_addr[3:0]};

  // The in-flight head must keep its data stable, so it is never a coalesce target.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && tag_q[i] == in_addr[31:4] &&
          !(state_q != IDLE && PW'(i) == head_q)) begin
        coal_hit = 1'b1;
        coal_idx = PW'(i);
      end
    end
  end

  assign not_full = count_q < CW'(DEPTH);
  assign in_rdy   = not_full | coal_hit;
  assign push     = in_req & ~coal_hit & not_full;
  assign pop      = (state_q == WAIT_B) & wr_bvalid;

  always_comb begin
    state_d = state_q;
    wr_req  = 1'b0;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = REQ;
      REQ: begin
        wr_req = 1'b1;
        if (wr_rdy) state_d = WAIT_B;
      end
      WAIT_B:  if (wr_bvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (in_req && coal_hit) data_d[coal_idx] = in_data;
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tag_d[tail_q]   = in_addr[31:4];
      data_d[tail_q]  = in_data;
      tail_d          = tail_q + 1'b1;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Walk oldest to youngest so the last match found is the youngest copy.
  always_comb begin
    snoop_hit  = 1'b0;
    snoop_data = '0;
    snp_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      snp_idx = head_q + PW'(k);
      if (valid_q[snp_idx] && tag_q[snp_idx] == snoop_addr[31:4]) begin
        snoop_hit  = 1'b1;
        snoop_data = data_q[snp_idx];
      end
    end
  end

  assign wr_addr = {tag_q[head_q], 4'b0000};
  assign wr_data = data_q[head_q];
  assign empty   = (count_q == '0) && (state_q == IDLE);
  assign count   = count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= valid_d[i];
        tag_q[i]   <= tag_d[i];
        data_q[i]  <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed self-checking bench for dcache_write_buffer: latency, full, coalesce, snoop,
// wrap-around with randomised bridge delays, and asynchronous reset during a drain.
module tb_dcache_write_buffer;

  localparam int DEPTH  = 4;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              resetn;
  logic              in_req;
  logic [31:0]       in_addr;
  logic [LINE_W-1:0] in_data;
  logic              in_rdy;
  logic              wr_req;
  logic [31:0]       wr_addr;
  logic [LINE_W-1:0] wr_data;
  logic              wr_rdy;
  logic              wr_bvalid;
  logic [31:0]       snoop_addr;
  logic              snoop_hit;
  logic [LINE_W-1:0] snoop_data;
  logic              empty;
  logic [2:0]        count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dcache_write_buffer #(.DEPTH(DEPTH), .LINE_W(LINE_W)) dut (
    .clk(clk), .resetn(resetn),
    .in_req(in_req), .in_addr(in_addr), .in_data(in_data), .in_rdy(in_rdy),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .wr_bvalid(wr_bvalid),
    .snoop_addr(snoop_addr), .snoop_hit(snoop_hit), .snoop_data(snoop_data),
    .empty(empty), .count(count)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [127:0] d, input logic exp_rdy);
    in_req = 1'b1; in_addr = a; in_data = d;
    #1;
    chk("in_rdy on push", in_rdy, exp_rdy);
    @(posedge clk); #1;
    in_req = 1'b0;
  endtask

  task automatic push_wait(input logic [31:0] a, input logic [127:0] d);
    int n = 0;
    in_req = 1'b1; in_addr = a; in_data = d;
    #1;
    while (in_rdy !== 1'b1 && n < 60) begin
      step(); #1; n++;
    end
    chk("push_wait in_rdy", in_rdy, 1'b1);
    @(posedge clk); #1;
    in_req = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (wr_req !== 1'b1 && n < 40) begin
      step(); n++;
    end
    chk({tag, " wr_req"}, wr_req, 1'b1);
  endtask

  task automatic drain_one(input string tag, input logic [31:0] a, input logic [127:0] d,
                           input int rdly, input int bdly);
    wait_req(tag);
    chk({tag, " addr"}, wr_addr, a);
    chk({tag, " data"}, wr_data, d);
    repeat (rdly) step();
    chk({tag, " data held"}, wr_data, d);
    wr_rdy = 1'b1;
    step();
    wr_rdy = 1'b0;
    repeat (bdly) step();
    chk({tag, " wr_req low in WAIT_B"}, wr_req, 1'b0);
    wr_bvalid = 1'b1;
    step();
    wr_bvalid = 1'b0;
  endtask

  function automatic logic [127:0] pat(input logic [31:0] base, input int i);
    logic [31:0] w;
    w = base + 32'(i);
    return {w, ~w, w ^ 32'h5A5A_5A5A, w + 32'h0101_0101};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] la, lb, lc;
    resetn = 1'b1; in_req = 1'b0; in_addr = '0; in_data = '0;
    wr_rdy = 1'b0; wr_bvalid = 1'b0; snoop_addr = '0;
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset wr_req", wr_req, 1'b0);
    chk("reset empty", empty, 1'b1);
    chk("reset in_rdy", in_rdy, 1'b1);
    chk("reset snoop_hit", snoop_hit, 1'b0);
    chk("reset count", count, 3'd0);
    resetn = 1'b1;
    step();

    // single line: wr_req two edges after acceptance
    push(32'h1000_0040, pat(32'hD000_0000, 0), 1'b1);
    chk("t1 count", count, 3'd1);
    chk("t1 wr_req +1", wr_req, 1'b0);
    chk("t1 empty", empty, 1'b0);
    step();
    chk("t1 wr_req +2", wr_req, 1'b1);
    chk("t1 wr_addr", wr_addr, 32'h1000_0040);
    chk("t1 wr_data", wr_data, pat(32'hD000_0000, 0));
    step();
    chk("t1 stalled wr_req", wr_req, 1'b1);
    wr_rdy = 1'b1;
    step();
    wr_rdy = 1'b0;
    chk("t1 WAIT_B wr_req", wr_req, 1'b0);
    chk("t1 WAIT_B empty", empty, 1'b0);
    step();
    wr_bvalid = 1'b1;
    step();
    wr_bvalid = 1'b0;
    chk("t1 empty after b", empty, 1'b1);
    chk("t1 count after b", count, 3'd0);

    // fill to full with the bridge stalled
    for (int i = 0; i < 4; i++) push(32'h4000_0000 + 32'(i * 256), pat(32'h1111_0000, i), 1'b1);
    chk("full count", count, 3'd4);
    in_req = 1'b1; in_addr = 32'h4000_0400; in_data = pat(32'h1111_0000, 4);
    #1;
    chk("full in_rdy", in_rdy, 1'b0);
    wait_req("full L0");
    chk("full L0 addr", wr_addr, 32'h4000_0000);
    wr_rdy = 1'b1;
    step();
    wr_rdy = 1'b0;
    wr_bvalid = 1'b1;
    #1;
    chk("full in_rdy during pop", in_rdy, 1'b0);
    step();
    wr_bvalid = 1'b0;
    in_req = 1'b0;
    chk("full in_rdy after pop", in_rdy, 1'b1);
    chk("full count after pop", count, 3'd3);
    for (int i = 1; i < 4; i++) drain_one("full drain", 32'h4000_0000 + 32'(i * 256), pat(32'h1111_0000, i), 0, 0);
    chk("full empty", empty, 1'b1);

    // coalesce and snoop
    la = 32'h3000_0010; lb = 32'h3000_0020; lc = 32'h3000_0030;
    push(la, pat(32'hAAAA_0000, 0), 1'b1);
    push(lb, pat(32'hBBBB_0000, 0), 1'b1);
    push(lc, pat(32'hCCCC_0000, 0), 1'b1);
    chk("coal head in flight", wr_req, 1'b1);
    push(lb, pat(32'hBBBB_0000, 1), 1'b1);
    chk("coal B count", count, 3'd3);
    push(32'h3000_001C, pat(32'hAAAA_0000, 1), 1'b1);
    chk("coal A new entry", count, 3'd4);
    push(lc, pat(32'hCCCC_0000, 1), 1'b1);
    chk("coal C while full", count, 3'd4);
    in_req = 1'b1; in_addr = 32'h3000_0040; in_data = '0;
    #1;
    chk("coal full distinct", in_rdy, 1'b0);
    in_req = 1'b0;
    snoop_addr = 32'h3000_0018;
    #1;
    chk("snoop A hit", snoop_hit, 1'b1);
    chk("snoop A youngest", snoop_data, pat(32'hAAAA_0000, 1));
    snoop_addr = lb;
    #1;
    chk("snoop B data", snoop_data, pat(32'hBBBB_0000, 1));
    snoop_addr = 32'h3000_0040;
    #1;
    chk("snoop absent", snoop_hit, 1'b0);
    drain_one("coal A", la, pat(32'hAAAA_0000, 0), 1, 0);
    drain_one("coal B'", lb, pat(32'hBBBB_0000, 1), 0, 1);
    drain_one("coal C'", lc, pat(32'hCCCC_0000, 1), 0, 0);
    drain_one("coal A'", la, pat(32'hAAAA_0000, 1), 0, 0);
    chk("coal empty", empty, 1'b1);

    // wrap-around with concurrent producer and randomly delayed bridge
    fork
      begin
        for (int i = 0; i < 10; i++) push_wait(32'h2000_0000 + 32'(i * 16), pat(32'hC0DE_0000, i));
      end
      begin
        for (int i = 0; i < 10; i++)
          drain_one("wrap", 32'h2000_0000 + 32'(i * 16), pat(32'hC0DE_0000, i),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
    join
    step();
    chk("wrap count", count, 3'd0);
    chk("wrap empty", empty, 1'b1);

    // asynchronous reset while waiting for the write response
    push(32'h5000_0000, pat(32'hEEEE_0000, 0), 1'b1);
    push(32'h5000_0010, pat(32'hEEEE_0000, 1), 1'b1);
    wait_req("rst X");
    wr_rdy = 1'b1;
    step();
    wr_rdy = 1'b0;
    chk("rst pre count", count, 3'd2);
    snoop_addr = 32'h5000_0000;
    #1;
    chk("rst pre snoop", snoop_hit, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("rst async wr_req", wr_req, 1'b0);
    chk("rst async count", count, 3'd0);
    chk("rst async empty", empty, 1'b1);
    chk("rst async in_rdy", in_rdy, 1'b1);
    chk("rst async snoop", snoop_hit, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;
    wr_bvalid = 1'b1;
    step();
    wr_bvalid = 1'b0;
    chk("rst stray b count", count, 3'd0);
    chk("rst stray b empty", empty, 1'b1);
    step();
    chk("rst stray b wr_req", wr_req, 1'b0);
    push(32'h6000_0000, pat(32'h7777_0000, 0), 1'b1);
    drain_one("rst after", 32'h6000_0000, pat(32'h7777_0000, 0), 0, 0);
    chk("rst after empty", empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
